// File: rtl/mul_share_pkg.sv
// Shared types, defaults and round-robin helper for the shared-multiplier arbiter.
package mul_share_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned WS_DEF   = 16;
    localparam int unsigned WL_DEF   = 32;
    localparam int unsigned LAT_DEF  = 3;

    // Upper bound on requesters; the picker works on a padded vector of this size.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    localparam int unsigned TAG_W = $clog2(NREQ_DEF);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic               valid;
        tag_t               tag;
        logic [WS_DEF-1:0]  a;
        logic [WS_DEF-1:0]  b;
    } stage_t;

    // First set bit of valid at or after ptr, wrapping modulo nreq; 0 when none set.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [IDX_W-1:0]   ptr,
                                                  input int unsigned        nreq);
        logic [IDX_W-1:0] pick;
        logic             found;
        logic [IDX_W:0]   idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(nreq)) begin
                idx = idx - (IDX_W+1)'(nreq);
            end
            if (i < nreq) begin
                if (!found && valid[idx[IDX_W-1:0]]) begin
                    pick  = idx[IDX_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_mul_pipe.sv
// Multiply pipeline with valid/tag sideband: LAT-1 operand stages, product formed
// combinationally at the tail so the caller's output register completes LAT cycles.
module mul_pipe #(
    parameter int unsigned WS  = 16,
    parameter int unsigned WL  = 32,
    parameter int unsigned LAT = 3,
    parameter int unsigned TW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    input  logic [WS-1:0] in_a,
    input  logic [WS-1:0] in_b,
    output logic          out_valid_c,
    output logic [TW-1:0] out_tag_c,
    output logic [WL-1:0] out_prod_c
);

    if (LAT == 1) begin : g_direct
        assign out_valid_c = in_valid;
        assign out_tag_c   = in_tag;
        assign out_prod_c  = WL'(in_a) * WL'(in_b);
    end else begin : g_stages
        localparam int unsigned NST = LAT - 1;

        typedef struct packed {
            logic [TW-1:0] tag;
            logic [WS-1:0] a;
            logic [WS-1:0] b;
        } pipe_data_t;

        logic [NST-1:0] vld;
        pipe_data_t     dq [NST];

        // Valid bits are the only reset state; dropping them discards in-flight work.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int unsigned i = 1; i < NST; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            dq[0] <= '{tag: in_tag, a: in_a, b: in_b};
            for (int unsigned i = 1; i < NST; i++) begin
                dq[i] <= dq[i-1];
            end
        end

        assign out_valid_c = vld[NST-1];
        assign out_tag_c   = dq[NST-1].tag;
        assign out_prod_c  = WL'(dq[NST-1].a) * WL'(dq[NST-1].b);
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters.
// Optional embedded properties: define MUL_SHARE_ARBITER_FORMAL_EN.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned WS   = WS_DEF,
    parameter int unsigned WL   = WL_DEF,
    parameter int unsigned LAT  = LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WS-1:0]         req_a,
    input  logic [NREQ*WS-1:0]         req_b,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [WL-1:0]              rsp_data,
    output logic [$clog2(LAT+1)-1:0]   inflight
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW = $clog2(LAT + 1);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_next_c;
    logic [PW-1:0]      grant_c;
    logic               any_c;
    logic [MAX_REQ-1:0] valid_pad_c;
    logic [WS-1:0]      sel_a_c;
    logic [WS-1:0]      sel_b_c;
    logic               pipe_valid_c;
    logic [PW-1:0]      pipe_tag_c;
    logic [WL-1:0]      pipe_prod_c;

    // Grant depends only on req_valid and ptr; a granted valid is always an acceptance.
    assign valid_pad_c = MAX_REQ'(req_valid);
    assign any_c       = |req_valid;
    assign grant_c     = PW'(rr_pick(valid_pad_c, IDX_W'(ptr), NREQ));

    always_comb begin
        req_ready = '0;
        if (any_c) begin
            req_ready = NREQ'(1) << grant_c;
        end
    end

    always_comb begin
        ptr_next_c = grant_c + PW'(1);
        if (grant_c == PW'(NREQ - 1)) begin
            ptr_next_c = '0;
        end
    end

    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PW'(i) == grant_c) begin
                sel_a_c = req_a[i*WS +: WS];
                sel_b_c = req_b[i*WS +: WS];
            end
        end
    end

    mul_pipe #(
        .WS  (WS),
        .WL  (WL),
        .LAT (LAT),
        .TW  (PW)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (any_c),
        .in_tag      (grant_c),
        .in_a        (sel_a_c),
        .in_b        (sel_b_c),
        .out_valid_c (pipe_valid_c),
        .out_tag_c   (pipe_tag_c),
        .out_prod_c  (pipe_prod_c)
    );

    // inflight counts an op until the end of its response cycle, so it peaks at LAT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            if (any_c) begin
                ptr <= ptr_next_c;
            end
            rsp_valid <= pipe_valid_c ? (NREQ'(1) << pipe_tag_c) : '0;
            if (pipe_valid_c) begin
                rsp_data <= pipe_prod_c;
            end
            inflight <= inflight + IW'(any_c) - IW'(|rsp_valid);
        end
    end

`ifdef MUL_SHARE_ARBITER_FORMAL_EN
    logic [WL-1:0] sh_prod [LAT];
    logic [3:0]    wait_cnt [NREQ];
    logic          f_past_valid = 1'b0;

    always_ff @(posedge clk) begin
        f_past_valid <= 1'b1;
    end

    always @(*) begin
        if (!f_past_valid) begin
            assume (!rst_n);
        end else begin
            assume (rst_n);
        end
    end

    // Reference product travels alongside the real pipeline and lands with rsp_valid.
    always_ff @(posedge clk) begin
        sh_prod[0] <= WL'(sel_a_c) * WL'(sel_b_c);
        for (int unsigned i = 1; i < LAT; i++) begin
            sh_prod[i] <= sh_prod[i-1];
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_props
        always_ff @(posedge clk) begin
            if (!rst_n || !req_valid[gi] || req_ready[gi]) begin
                wait_cnt[gi] <= '0;
            end else begin
                wait_cnt[gi] <= wait_cnt[gi] + 4'd1;
            end
        end

        assume property (@(posedge clk) disable iff (!rst_n)
            (req_valid[gi] && !req_ready[gi]) |=>
                (req_valid[gi] && $stable(req_a[gi*WS +: WS]) && $stable(req_b[gi*WS +: WS])));

        assert property (@(posedge clk) disable iff (!rst_n) wait_cnt[gi] < 4'(NREQ));
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
    assert property (@(posedge clk) disable iff (!rst_n) inflight <= IW'(LAT));
    assert property (@(posedge clk) disable iff (!rst_n)
        (|rsp_valid) |-> (rsp_data == sh_prod[LAT-1]));
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined unsigned multiplier among NREQ requesters.
- Uses a round-robin arbiter with a valid/ready operand handshake.
- Returns each product to the requester that issued it, tagged by requester ID.
- Sits between client blocks and the multiply datapath. Carries optional embedded formal properties in the style of the block-level benchmarks.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WS, 16, operand width in bits
- WL, 32, product width in bits (WL = 2*WS)
- LAT, 3, multiplier pipeline depth in cycles (>= 1)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept; at most one bit high
- req_a  input  NREQ*WS  operand A per requester; slice i = [i*WS +: WS]
- req_b  input  NREQ*WS  operand B per requester; same slicing as req_a
- rsp_valid  output  NREQ  one-hot0 result strobe
- rsp_data  output  WL  product, shared bus
- inflight  output  $clog2(LAT+1)  operations currently in the pipeline

Behaviour:
- Clock and reset: clock clk; reset rst_n, synchronous, active-low.
- Reset values:
  - rr pointer = 0
  - all pipeline valid bits = 0
  - rsp_valid = 0, rsp_data = 0, inflight = 0
  - pipeline data/tag registers need not be reset.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NREQ; the first set bit is the grant g.
  - req_ready = onehot(g) when any req_valid is set, else 0.
  - req_ready depends only on req_valid and ptr, never on operand values.
- Acceptance:
  - Occurs on the edge where req_valid[g] && req_ready[g].
  - ptr <= (g+1) mod NREQ on acceptance; ptr holds otherwise.
  - The pipeline never stalls, so one acceptance per cycle is possible.
- Pipeline:
  - Stage 0 captures {valid, tag=g, a, b}.
  - Stages 1..LAT-1 shift.
  - Product = a*b, zero-extended, full WL bits, no truncation.
  - Operands accepted at edge k produce rsp_valid[tag]=1 and rsp_data=product in the cycle after edge k+LAT-1, i.e. LAT cycles of latency.
  - rsp_valid is a registered output.
- Responses:
  - No response backpressure; each rsp_valid pulse lasts exactly 1 cycle.
  - rsp_data holds its last value when rsp_valid = 0.
- Ordering: responses leave in acceptance order.
- inflight: +1 on acceptance, -1 on response; both in the same cycle gives net 0. Range 0..LAT.
- Requester obligation: once req_valid[i] is high, it and its operands stay stable until accepted.
- Fairness: a requester holding valid is granted within NREQ cycles.
- Boundary conditions:
  - NREQ=1: degenerates to passthrough arbitration.
  - ptr wraps from NREQ-1 to 0.
  - Operand 0 or all-ones: exact product, e.g. 0xFFFF*0xFFFF = 0xFFFE0001.
  - Reset mid-operation: all in-flight operations are dropped with no response. The first cycle after reset deassertion behaves as post-reset.

Optional Feature:
- Macro: MUL_SHARE_ARBITER_FORMAL_EN
- When defined, the block contains:
  - assume !rst_n == $initstate
  - assume stability of req_valid/req_a/req_b while pending
  - assert $onehot0(req_ready) and $onehot0(rsp_valid)
  - assert inflight <= LAT
  - assert rsp_data == shadow product of the oldest accepted operands, using a reference multiply of the captured operands
  - assert per-requester wait counter < NREQ
  - all asserts are gated by rst_n.
- When undefined: pure synthesizable RTL with no assume/assert statements and identical port behaviour.

Decomposition:
- Package mul_share_pkg holds:
  - default WS/WL/LAT/NREQ localparams
  - typedef of the tag type (logic [$clog2(NREQ)-1:0])
  - typedef of the stage struct {valid, tag, a, b}
  - function rr_pick(valid, ptr) returning the grant index.
- One sub-module: mul_pipe (WS, WL, LAT), a LAT-stage multiply that carries a valid/tag sideband; the arbiter wraps it.

Test Plan:
- Reset then idle, no valid -> req_ready=0, rsp_valid=0, inflight=0 for 10 cycles.
- Single requester 2: a=3, b=5 at cycle 0 -> req_ready[2]=1 at cycle 0; rsp_valid=4'b0100, rsp_data=15 at cycle LAT=3.
- All 4 requesters valid continuously, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; each response tagged correctly, one per cycle, inflight steady at 3.
- Requester 1 a=0xFFFF, b=0xFFFF; requester 3 a=0, b=0x1234 back-to-back -> rsp_data 0xFFFE0001 then 0x00000000 on consecutive cycles.
- Accept 2 ops, assert rst_n=0 for 1 cycle at cycle 1 -> no rsp_valid ever for those ops, inflight=0, ptr=0.
- Requester 0 valid continuously while 1..3 also valid -> requester 0 waits at most 3 cycles between grants.
